// File: rtl/axi_default_slave.sv
// Default (unmapped) AXI4 slave: accepts every transaction routed to it and completes it with a
// DECERR response. The write and read channels run on two independent state machines.
module axi_default_slave #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // write address
  input  logic [ID_W-1:0]   AWID,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  // write response
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // read address
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {
    WIdle = 2'd0,
    WData = 2'd1,
    WResp = 2'd2
  } w_state_e;

  typedef enum logic {
    RIdle = 1'b0,
    RData = 1'b1
  } r_state_e;

  w_state_e             w_state_q, w_state_d;
  logic [ID_W-1:0]      bid_q, bid_d;
  r_state_e             r_state_q, r_state_d;
  logic [ID_W-1:0]      rid_q, rid_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;

  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                 last_beat;

  // The burst length is irrelevant on the write side: WLAST alone closes the burst.
  logic                 unused_awlen;
  assign unused_awlen = ^AWLEN;

  // Ready/valid are pure decodes of state, so no input reaches an output combinationally.
  assign AWREADY   = (w_state_q == WIdle);
  assign WREADY    = (w_state_q == WData);
  assign BVALID    = (w_state_q == WResp);
  assign BID       = bid_q;
  assign BRESP     = RespDecErr;

  assign last_beat = (cnt_q == '0);
  assign ARREADY   = (r_state_q == RIdle);
  assign RVALID    = (r_state_q == RData);
  assign RLAST     = RVALID && last_beat;
  assign RID       = rid_q;
  assign RDATA     = '0;
  assign RRESP     = RespDecErr;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  // Write channel
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          bid_d     = AWID;
          w_state_d = WData;
        end
      end
      WData: begin
        if (w_hs && WLAST) begin
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (b_hs) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= WIdle;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
    end
  end

  // Read channel: cnt holds the number of beats still to go after the current one.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    cnt_d     = cnt_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          rid_d     = ARID;
          cnt_d     = ARLEN;
          r_state_d = RData;
        end
      end
      RData: begin
        if (r_hs) begin
          if (last_beat) begin
            r_state_d = RIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= RIdle;
      rid_q     <= '0;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: directed scenarios plus randomized transactions, each checked
// against transaction-level expectations (beat counts, IDs, DECERR) held in the bench.
module tb_axi_default_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID;
  logic [3:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [3:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int passed = 0;
  int total  = 0;

  always #5 ACLK = ~ACLK;

  axi_default_slave #(.ID_W(8), .DATA_W(32), .LEN_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
  task automatic cyc();
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    total++; if (AWREADY !== 1'b1) $display("FAIL reset_awready: got %b want 1", AWREADY); else passed++;
    total++; if (ARREADY !== 1'b1) $display("FAIL reset_arready: got %b want 1", ARREADY); else passed++;
    total++; if (WREADY !== 1'b0) $display("FAIL reset_wready: got %b want 0", WREADY); else passed++;
    total++; if (BVALID !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", BVALID); else passed++;
    total++; if (RVALID !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", RVALID); else passed++;
    total++; if (RLAST !== 1'b0) $display("FAIL reset_rlast: got %b want 0", RLAST); else passed++;
    total++; if (BID !== 8'h00) $display("FAIL reset_bid: got %h want 00", BID); else passed++;
    total++; if (RID !== 8'h00) $display("FAIL reset_rid: got %h want 00", RID); else passed++;
  endtask

  // One write transaction of nbeats W beats. gap_pct: chance of an idle W cycle.
  // bdelay: cycles BREADY stays low once the response is due.
  task automatic do_write(input logic [7:0] id, input int nbeats, input int gap_pct,
                          input int bdelay);
    int sent;
    int budget;
    total++; if (AWREADY !== 1'b1) $display("FAIL wr_awready_idle: got %b want 1", AWREADY); else passed++;
    total++; if (WREADY !== 1'b0) $display("FAIL wr_wready_idle: got %b want 0", WREADY); else passed++;
    AWID    = id;
    AWLEN   = 4'($urandom_range(15));
    AWVALID = 1'b1;
    // A W beat offered alongside AW must not be taken before AW is accepted.
    WVALID  = 1'b1;
    WLAST   = 1'b1;
    cyc();
    AWVALID = 1'b0;
    AWID    = 8'hxx;
    total++; if (AWREADY !== 1'b0) $display("FAIL wr_awready_busy: got %b want 0", AWREADY); else passed++;
    sent   = 0;
    budget = 0;
    while (sent < nbeats && budget < 400) begin
      WVALID = ($urandom_range(99) >= gap_pct);
      WLAST  = (sent == nbeats - 1);
      total++; if (WREADY !== 1'b1) $display("FAIL wr_wready_data: got %b want 1 (beat %0d)", WREADY, sent); else passed++;
      total++; if (BVALID !== 1'b0) $display("FAIL wr_bvalid_early: got %b want 0 (beat %0d)", BVALID, sent); else passed++;
      if (WVALID) sent++;
      budget++;
      cyc();
    end
    total++; if (sent != nbeats) $display("FAIL wr_beat_budget: sent %0d want %0d", sent, nbeats); else passed++;
    WVALID = 1'b0;
    WLAST  = 1'b0;
    for (int d = 0; d <= bdelay; d++) begin
      BREADY = (d == bdelay);
      total++; if (BVALID !== 1'b1) $display("FAIL wr_bvalid: got %b want 1 (wait %0d)", BVALID, d); else passed++;
      total++; if (BID !== id) $display("FAIL wr_bid: got %h want %h", BID, id); else passed++;
      total++; if (BRESP !== 2'b11) $display("FAIL wr_bresp: got %b want 11", BRESP); else passed++;
      total++; if (WREADY !== 1'b0) $display("FAIL wr_wready_resp: got %b want 0", WREADY); else passed++;
      cyc();
    end
    BREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (BVALID !== 1'b0) $display("FAIL wr_extra_b: got %b want 0", BVALID); else passed++;
      total++; if (AWREADY !== 1'b1) $display("FAIL wr_awready_after: got %b want 1", AWREADY); else passed++;
      cyc();
    end
  endtask

  // One read transaction. mode 0: RREADY always high, 1: toggling, 2: random (stall_pct).
  task automatic do_read(input logic [7:0] id, input logic [3:0] len, input int mode,
                         input int stall_pct);
    int beats;
    int want;
    int budget;
    want = int'(len) + 1;
    total++; if (ARREADY !== 1'b1) $display("FAIL rd_arready_idle: got %b want 1", ARREADY); else passed++;
    ARID    = id;
    ARLEN   = len;
    ARVALID = 1'b1;
    cyc();
    ARVALID = 1'b0;
    ARID    = 8'hxx;
    ARLEN   = 4'hx;
    beats  = 0;
    budget = 0;
    while (beats < want && budget < 400) begin
      case (mode)
        0:       RREADY = 1'b1;
        1:       RREADY = budget[0];
        default: RREADY = ($urandom_range(99) >= stall_pct);
      endcase
      total++; if (RVALID !== 1'b1) $display("FAIL rd_rvalid: got %b want 1 (beat %0d)", RVALID, beats); else passed++;
      total++; if (ARREADY !== 1'b0) $display("FAIL rd_arready_busy: got %b want 0", ARREADY); else passed++;
      total++; if (RID !== id) $display("FAIL rd_rid: got %h want %h", RID, id); else passed++;
      total++; if (RDATA !== 32'h0) $display("FAIL rd_rdata: got %h want 0", RDATA); else passed++;
      total++; if (RRESP !== 2'b11) $display("FAIL rd_rresp: got %b want 11", RRESP); else passed++;
      total++; if (RLAST !== (beats == want - 1)) $display("FAIL rd_rlast: got %b want %b (beat %0d of %0d)", RLAST, (beats == want - 1), beats + 1, want); else passed++;
      if (RREADY) beats++;
      budget++;
      cyc();
    end
    total++; if (beats != want) $display("FAIL rd_beat_budget: got %0d want %0d", beats, want); else passed++;
    RREADY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      total++; if (RVALID !== 1'b0) $display("FAIL rd_extra_beat: got %b want 0", RVALID); else passed++;
      total++; if (ARREADY !== 1'b1) $display("FAIL rd_arready_after: got %b want 1", ARREADY); else passed++;
      cyc();
    end
    RREADY = 1'b0;
  endtask

  task automatic test_single_write();
    do_write(8'h15, 1, 0, 0);
  endtask

  task automatic test_write_backpressure();
    do_write(8'hC3, 4, 40, 3);
  endtask

  task automatic test_read_burst();
    do_read(8'h2A, 4'd3, 1, 0);
  endtask

  task automatic test_max_read();
    do_read(8'h5E, 4'hF, 0, 0);
  endtask

  // Expected per-cycle behaviour after a simultaneous AW/AR: write is 1 beat, BREADY high;
  // read is 3 beats, RREADY high.
  task automatic test_concurrent();
    AWID = 8'h33; AWVALID = 1'b1;
    ARID = 8'h44; ARLEN = 4'd2; ARVALID = 1'b1;
    cyc();
    AWVALID = 1'b0; ARVALID = 1'b0;
    total++; if (AWREADY !== 1'b0) $display("FAIL cc_aw_taken: got %b want 0", AWREADY); else passed++;
    total++; if (ARREADY !== 1'b0) $display("FAIL cc_ar_taken: got %b want 0", ARREADY); else passed++;
    BREADY = 1'b1;
    RREADY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      WVALID = (c == 0);
      WLAST  = (c == 0);
      total++; if (WREADY !== (c == 0)) $display("FAIL cc_wready: got %b want %b (cycle %0d)", WREADY, (c == 0), c); else passed++;
      total++; if (BVALID !== (c == 1)) $display("FAIL cc_bvalid: got %b want %b (cycle %0d)", BVALID, (c == 1), c); else passed++;
      if (c == 1) begin
        total++; if (BID !== 8'h33) $display("FAIL cc_bid: got %h want 33", BID); else passed++;
      end
      total++; if (RVALID !== (c < 3)) $display("FAIL cc_rvalid: got %b want %b (cycle %0d)", RVALID, (c < 3), c); else passed++;
      total++; if (RLAST !== (c == 2)) $display("FAIL cc_rlast: got %b want %b (cycle %0d)", RLAST, (c == 2), c); else passed++;
      if (c < 3) begin
        total++; if (RID !== 8'h44) $display("FAIL cc_rid: got %h want 44", RID); else passed++;
      end
      cyc();
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int beats;
    ARID = 8'h6B; ARLEN = 4'd7; ARVALID = 1'b1;
    cyc();
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    beats   = 0;
    while (beats < 2) begin
      total++; if (RVALID !== 1'b1) $display("FAIL rst_rvalid_pre: got %b want 1", RVALID); else passed++;
      beats++;
      cyc();
    end
    ARESETn = 1'b0;
    #1;
    total++; if (RVALID !== 1'b0) $display("FAIL rst_rvalid_now: got %b want 0", RVALID); else passed++;
    total++; if (RLAST !== 1'b0) $display("FAIL rst_rlast_now: got %b want 0", RLAST); else passed++;
    total++; if (ARREADY !== 1'b1) $display("FAIL rst_arready_now: got %b want 1", ARREADY); else passed++;
    total++; if (RID !== 8'h00) $display("FAIL rst_rid_now: got %h want 00", RID); else passed++;
    cyc();
    cyc();
    ARESETn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      total++; if (RVALID !== 1'b0) $display("FAIL rst_stray_beat: got %b want 0 (cycle %0d)", RVALID, k); else passed++;
      total++; if (ARREADY !== 1'b1) $display("FAIL rst_arready_after: got %b want 1", ARREADY); else passed++;
    end
    RREADY = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1) == 0) begin
        do_write(8'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(0, 60)),
                 int'($urandom_range(0, 4)));
      end else begin
        do_read(8'($urandom), 4'($urandom_range(15)), 2, int'($urandom_range(0, 60)));
      end
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWLEN = '0; AWVALID = 1'b0;
    WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    cyc();
    test_reset();
    cyc();
    ARESETn = 1'b1;
    cyc();
    test_single_write();
    test_write_backpressure();
    test_read_burst();
    test_max_read();
    test_concurrent();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
